// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//
// Match controller for a two-player paddle game. Tracks each player's points
// (first to 3 wins), decides who serves next, and inserts a fixed dead time
// after every non-winning point before play resumes.
//
// States:
//   IDLE  - no game yet; waiting for a start edge.
//   PAUSE - dead time between points; counter runs down to 0.
//   PLAY  - rally in progress; ball logic may serve while serve_ready is high.
//   OVER  - a player reached 3; scores hold until the next start edge.
//
// Ports:
//   clock        in   system clock, all updates on its rising edge
//   reset        in   synchronous, active-high reset
//   start        in   start/restart level; acted on at its rising edge
//   left_point   in   left player won the rally (level); rising edge scores
//   right_point  in   right player won the rally (level); rising edge scores
//   leftpscore   out  left player points, 0..3
//   rightpscore  out  right player points, 0..3
//   gamestate    out  1 in PAUSE or PLAY
//   serve_side   out  0 = left serves next, 1 = right serves next
//   serve_ready  out  1 only in PLAY
//   state_dbg    out  raw FSM state (0 IDLE, 1 PAUSE, 2 PLAY, 3 OVER)
//
// Handshake: there is no valid/ready pair here; each input is a level and an
// event is its 0->1 transition against the value registered on the previous
// edge. serve_ready is a status level, not a handshake.
// -----------------------------------------------------------------------------
module score_keeper #(
    parameter int unsigned PAUSE_CYCLES = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       left_point,
    input  logic       right_point,
    output logic [1:0] leftpscore,
    output logic [1:0] rightpscore,
    output logic       gamestate,
    output logic       serve_side,
    output logic       serve_ready,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PAUSE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    // Loading N-1 and leaving PAUSE on the edge that sees 0 makes the stay
    // in PAUSE exactly PAUSE_CYCLES edges long.
    localparam logic [25:0] PAUSE_LOAD = 26'(PAUSE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  left_score_q, left_score_d;
    logic [1:0]  right_score_q, right_score_d;
    logic        serve_side_q, serve_side_d;
    logic [25:0] cnt_q, cnt_d;
    logic        start_prev_q, start_prev_d;
    logic        left_prev_q, left_prev_d;
    logic        right_prev_q, right_prev_d;

    logic start_rise;
    logic left_rise;
    logic right_rise;

    // Edge registers are updated in every state, so a level held high across
    // entry into PLAY has already been seen and cannot score.
    assign start_rise = start & ~start_prev_q;
    assign left_rise  = left_point & ~left_prev_q;
    assign right_rise = right_point & ~right_prev_q;

    always_comb begin
        state_d       = state_q;
        left_score_d  = left_score_q;
        right_score_d = right_score_q;
        serve_side_d  = serve_side_q;
        cnt_d         = cnt_q;
        start_prev_d  = start;
        left_prev_d   = left_point;
        right_prev_d  = right_point;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    state_d       = ST_PAUSE;
                    left_score_d  = 2'd0;
                    right_score_d = 2'd0;
                    serve_side_d  = 1'b0;
                    cnt_d         = PAUSE_LOAD;
                end
            end

            ST_PAUSE: begin
                if (cnt_q == 26'd0) begin
                    state_d = ST_PLAY;
                end else begin
                    cnt_d = cnt_q - 26'd1;
                end
            end

            ST_PLAY: begin
                // Both edges together is a let: nothing changes.
                if (left_rise && !right_rise) begin
                    left_score_d = left_score_q + 2'd1;
                    serve_side_d = 1'b0;
                    if (left_score_q == 2'd2) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_PAUSE;
                        cnt_d   = PAUSE_LOAD;
                    end
                end else if (right_rise && !left_rise) begin
                    right_score_d = right_score_q + 2'd1;
                    serve_side_d  = 1'b1;
                    if (right_score_q == 2'd2) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_PAUSE;
                        cnt_d   = PAUSE_LOAD;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            left_score_q  <= 2'd0;
            right_score_q <= 2'd0;
            serve_side_q  <= 1'b0;
            cnt_q         <= 26'd0;
            start_prev_q  <= 1'b0;
            left_prev_q   <= 1'b0;
            right_prev_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            left_score_q  <= left_score_d;
            right_score_q <= right_score_d;
            serve_side_q  <= serve_side_d;
            cnt_q         <= cnt_d;
            start_prev_q  <= start_prev_d;
            left_prev_q   <= left_prev_d;
            right_prev_q  <= right_prev_d;
        end
    end

    assign leftpscore  = left_score_q;
    assign rightpscore = right_score_q;
    assign serve_side  = serve_side_q;
    assign gamestate   = (state_q == ST_PAUSE) || (state_q == ST_PLAY);
    assign serve_ready = (state_q == ST_PLAY);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PAUSE = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  logic       clock;
  logic       reset;
  logic       start;
  logic       left_point;
  logic       right_point;
  logic [1:0] leftpscore;
  logic [1:0] rightpscore;
  logic       gamestate;
  logic       serve_side;
  logic       serve_ready;
  logic [1:0] state_dbg;

  int checks;
  int failures;

  score_keeper #(.PAUSE_CYCLES(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .left_point  (left_point),
    .right_point (right_point),
    .leftpscore  (leftpscore),
    .rightpscore (rightpscore),
    .gamestate   (gamestate),
    .serve_side  (serve_side),
    .serve_ready (serve_ready),
    .state_dbg   (state_dbg)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // advance one rising edge, then settle away from it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; left_point = 1'b1; right_point = 1'b0;
    step();
    step();
    checks++; if (state_dbg !== S_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_IDLE); end
    checks++; if (leftpscore !== 2'd0 || rightpscore !== 2'd0) begin failures++; $display("FAIL reset_scores: got %0d/%0d expected 0/0", leftpscore, rightpscore); end
    checks++; if (gamestate !== 1'b0 || serve_ready !== 1'b0 || serve_side !== 1'b0) begin failures++; $display("FAIL reset_flags: got gs=%b sr=%b ss=%b expected 0 0 0", gamestate, serve_ready, serve_side); end
    reset = 1'b0; start = 1'b0; left_point = 1'b0;
    step();
    checks++; if (state_dbg !== S_IDLE) begin failures++; $display("FAIL reset_release_idle: got %0d expected %0d", state_dbg, S_IDLE); end
  endtask

  task automatic test_start();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (gamestate !== 1'b1 || state_dbg !== S_PAUSE) begin failures++; $display("FAIL start_enter_pause: got gs=%b st=%0d expected gs=1 st=%0d", gamestate, state_dbg, S_PAUSE); end
    checks++; if (leftpscore !== 2'd0 || rightpscore !== 2'd0 || serve_side !== 1'b0) begin failures++; $display("FAIL start_scores: got %0d/%0d ss=%b expected 0/0 ss=0", leftpscore, rightpscore, serve_side); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (serve_ready !== 1'b0) begin failures++; $display("FAIL start_pause_cycle%0d: got serve_ready=%b expected 0", i + 1, serve_ready); end
    end
    step();
    checks++; if (serve_ready !== 1'b1 || state_dbg !== S_PLAY) begin failures++; $display("FAIL start_play_entry: got sr=%b st=%0d expected sr=1 st=%0d", serve_ready, state_dbg, S_PLAY); end
  endtask

  task automatic test_point_held();
    left_point = 1'b1;
    step();
    checks++; if (leftpscore !== 2'd1 || serve_side !== 1'b0) begin failures++; $display("FAIL held_first_edge: got L=%0d ss=%b expected L=1 ss=0", leftpscore, serve_side); end
    checks++; if (serve_ready !== 1'b0 || gamestate !== 1'b1) begin failures++; $display("FAIL held_pause_entry: got sr=%b gs=%b expected sr=0 gs=1", serve_ready, gamestate); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (leftpscore !== 2'd1 || serve_ready !== 1'b0) begin failures++; $display("FAIL held_level%0d: got L=%0d sr=%b expected L=1 sr=0", i + 1, leftpscore, serve_ready); end
    end
    left_point = 1'b0;
    step();
    checks++; if (serve_ready !== 1'b0) begin failures++; $display("FAIL held_pause_last: got sr=%b expected 0", serve_ready); end
    step();
    checks++; if (serve_ready !== 1'b1 || leftpscore !== 2'd1 || rightpscore !== 2'd0) begin failures++; $display("FAIL held_resume: got sr=%b L=%0d R=%0d expected sr=1 L=1 R=0", serve_ready, leftpscore, rightpscore); end
  endtask

  task automatic test_let();
    left_point = 1'b1; right_point = 1'b1;
    step();
    checks++; if (leftpscore !== 2'd1 || rightpscore !== 2'd0) begin failures++; $display("FAIL let_scores: got %0d/%0d expected 1/0", leftpscore, rightpscore); end
    checks++; if (state_dbg !== S_PLAY || serve_ready !== 1'b1) begin failures++; $display("FAIL let_state: got st=%0d sr=%b expected st=%0d sr=1", state_dbg, serve_ready, S_PLAY); end
    left_point = 1'b0; right_point = 1'b0;
    step();
    right_point = 1'b1;
    step();
    checks++; if (rightpscore !== 2'd1 || serve_side !== 1'b1 || serve_ready !== 1'b0) begin failures++; $display("FAIL let_then_right: got R=%0d ss=%b sr=%b expected R=1 ss=1 sr=0", rightpscore, serve_side, serve_ready); end
    right_point = 1'b0;
    step();
    // new edge during PAUSE, then held high across entry into PLAY
    right_point = 1'b1;
    step();
    checks++; if (rightpscore !== 2'd1) begin failures++; $display("FAIL pause_point_ignored: got R=%0d expected 1", rightpscore); end
    step();
    step();
    checks++; if (serve_ready !== 1'b1 || rightpscore !== 2'd1) begin failures++; $display("FAIL held_across_entry: got sr=%b R=%0d expected sr=1 R=1", serve_ready, rightpscore); end
    step();
    checks++; if (serve_ready !== 1'b1 || rightpscore !== 2'd1) begin failures++; $display("FAIL held_in_play: got sr=%b R=%0d expected sr=1 R=1", serve_ready, rightpscore); end
    right_point = 1'b0;
    step();
  endtask

  task automatic test_right_wins();
    right_point = 1'b1;
    step();
    right_point = 1'b0;
    checks++; if (rightpscore !== 2'd2 || serve_ready !== 1'b0) begin failures++; $display("FAIL win_second_point: got R=%0d sr=%b expected R=2 sr=0", rightpscore, serve_ready); end
    for (int i = 0; i < 3; i++) step();
    step();
    checks++; if (serve_ready !== 1'b1) begin failures++; $display("FAIL win_resume: got sr=%b expected 1", serve_ready); end
    right_point = 1'b1;
    step();
    right_point = 1'b0;
    checks++; if (rightpscore !== 2'd3 || leftpscore !== 2'd1) begin failures++; $display("FAIL win_final_score: got %0d/%0d expected 1/3", leftpscore, rightpscore); end
    checks++; if (state_dbg !== S_OVER || gamestate !== 1'b0 || serve_ready !== 1'b0) begin failures++; $display("FAIL win_over: got st=%0d gs=%b sr=%b expected st=%0d gs=0 sr=0", state_dbg, gamestate, serve_ready, S_OVER); end
    for (int i = 0; i < 10; i++) begin
      left_point = (i == 2 || i == 6) ? 1'b1 : 1'b0;
      right_point = (i == 4 || i == 6) ? 1'b1 : 1'b0;
      step();
      checks++; if (serve_ready !== 1'b0 || gamestate !== 1'b0 || leftpscore !== 2'd1 || rightpscore !== 2'd3) begin failures++; $display("FAIL over_hold%0d: got sr=%b gs=%b %0d/%0d expected sr=0 gs=0 1/3", i, serve_ready, gamestate, leftpscore, rightpscore); end
    end
    left_point = 1'b0; right_point = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (leftpscore !== 2'd0 || rightpscore !== 2'd0 || gamestate !== 1'b1 || serve_side !== 1'b0) begin failures++; $display("FAIL over_restart: got %0d/%0d gs=%b ss=%b expected 0/0 gs=1 ss=0", leftpscore, rightpscore, gamestate, serve_side); end
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 3; i++) step();
    step();
    checks++; if (serve_ready !== 1'b1) begin failures++; $display("FAIL ign_reach_play: got sr=%b expected 1", serve_ready); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (state_dbg !== S_PLAY || leftpscore !== 2'd0 || rightpscore !== 2'd0) begin failures++; $display("FAIL ign_start_in_play: got st=%0d %0d/%0d expected st=%0d 0/0", state_dbg, leftpscore, rightpscore, S_PLAY); end
    step();
    left_point = 1'b1;
    step();
    left_point = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++; if (serve_ready !== 1'b0) begin failures++; $display("FAIL ign_start_pause_mid: got sr=%b expected 0", serve_ready); end
    step();
    checks++; if (serve_ready !== 1'b1 || leftpscore !== 2'd1) begin failures++; $display("FAIL ign_start_in_pause: got sr=%b L=%0d expected sr=1 L=1", serve_ready, leftpscore); end
  endtask

  task automatic test_reset_mid_pause();
    right_point = 1'b1;
    step();
    right_point = 1'b0;
    for (int i = 0; i < 4; i++) step();
    left_point = 1'b1;
    step();
    left_point = 1'b0;
    step();
    checks++; if (leftpscore !== 2'd2 || rightpscore !== 2'd1 || state_dbg !== S_PAUSE) begin failures++; $display("FAIL midpause_setup: got %0d/%0d st=%0d expected 2/1 st=%0d", leftpscore, rightpscore, state_dbg, S_PAUSE); end
    reset = 1'b1; start = 1'b1;
    step();
    checks++; if (state_dbg !== S_IDLE || leftpscore !== 2'd0 || rightpscore !== 2'd0) begin failures++; $display("FAIL midpause_reset: got st=%0d %0d/%0d expected st=%0d 0/0", state_dbg, leftpscore, rightpscore, S_IDLE); end
    checks++; if (gamestate !== 1'b0 || serve_ready !== 1'b0) begin failures++; $display("FAIL midpause_flags: got gs=%b sr=%b expected 0 0", gamestate, serve_ready); end
    reset = 1'b0; start = 1'b0;
    step();
    checks++; if (gamestate !== 1'b0) begin failures++; $display("FAIL midpause_start_ignored: got gs=%b expected 0", gamestate); end
    left_point = 1'b1;
    step();
    left_point = 1'b0; right_point = 1'b1;
    step();
    right_point = 1'b0;
    step();
    checks++; if (leftpscore !== 2'd0 || rightpscore !== 2'd0 || state_dbg !== S_IDLE) begin failures++; $display("FAIL idle_points_ignored: got %0d/%0d st=%0d expected 0/0 st=%0d", leftpscore, rightpscore, state_dbg, S_IDLE); end
    // start held through reset release counts as an edge on the first free edge
    reset = 1'b1; start = 1'b1;
    step();
    reset = 1'b0;
    step();
    checks++; if (gamestate !== 1'b1 || state_dbg !== S_PAUSE) begin failures++; $display("FAIL held_start_after_reset: got gs=%b st=%0d expected gs=1 st=%0d", gamestate, state_dbg, S_PAUSE); end
    start = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1; start = 1'b0; left_point = 1'b0; right_point = 1'b0;
    test_reset();
    test_start();
    test_point_held();
    test_let();
    test_right_wins();
    test_start_ignored();
    test_reset_mid_pause();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
